sdram_responder: RTL and testbench

//  Responder end of the SDRAM word-access protocol that mport_manager initiates.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/sdram_responder_if.sv | 28 ++
 rtl/sdram_word_store.sv | 26 ++
 rtl/sdram_responder.sv | 173 +++++++++++++++++
 tb/tb_sdram_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================
// mem_pkg: shared types and constants for the SDRAM responder
// Rev 1.0
// ============================================================
package mem_pkg;
  typedef logic [22:0] sdram_addr_t;
  typedef logic [15:0] sdram_data_t;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    ACCESS  = 3'd2,
    DONE    = 3'd3,
    REFRESH = 3'd4
  } sdram_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage
`default_nettype wire

// File: rtl/sdram_responder_if.sv
`default_nettype none
// ============================================================
// sdram_responder_if: request/response bundle between initiator and responder
// Rev 1.0
// ============================================================
interface sdram_responder_if;
  import mem_pkg::*;

  logic        SDRAM_pll_locked;
  logic        SDRAM_ready;
  logic        SDRAM_as;
  logic        SDRAM_rw;
  sdram_addr_t SDRAM_addr;
  sdram_data_t SDRAM_data_write;
  sdram_data_t SDRAM_data_read;
  logic        SDRAM_done;

  modport master (
    output SDRAM_pll_locked, SDRAM_as, SDRAM_rw, SDRAM_addr, SDRAM_data_write,
    input  SDRAM_ready, SDRAM_data_read, SDRAM_done
  );

  modport slave (
    input  SDRAM_pll_locked, SDRAM_as, SDRAM_rw, SDRAM_addr, SDRAM_data_write,
    output SDRAM_ready, SDRAM_data_read, SDRAM_done
  );
endinterface
`default_nettype wire

// File: rtl/sdram_word_store.sv
`default_nettype none
// ============================================================
// sdram_word_store: single-port synchronous word RAM, 1-cycle read
// Rev 1.0
// ============================================================
module sdram_word_store
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  sdram_data_t           wdata,
  output sdram_data_t           rdata
);
  sdram_data_t mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end
endmodule
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================
// sdram_responder: SDRAM word-access responder backed by an on-chip store.
// Optional refresh modelling under SDRAM_REFRESH_EN.   Rev 1.0
// ============================================================
module sdram_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int INIT_CYCLES = 16,
  parameter int ACC_LAT     = 3
`ifdef SDRAM_REFRESH_EN
  ,
  parameter int REF_PERIOD  = 64,
  parameter int REF_CYCLES  = 4
`endif
) (
  input logic              clk,
  input logic              rst_l,
  sdram_responder_if.slave bus
);
  localparam int CNT_W = 16;

  sdram_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rw_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DEPTH_LOG2-1:0] store_addr;
  sdram_data_t           wdata_q, rdata_q, store_rdata;
  logic                  accept, we, load_rd, ready, done;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the store.
  assign unused_addr_hi = ^bus.SDRAM_addr[22:DEPTH_LOG2];

`ifdef SDRAM_REFRESH_EN
  logic [CNT_W-1:0] ref_cnt_q;
  logic             ref_pend_q, ref_take, ref_wrap;

  assign ref_wrap = (ref_cnt_q == CNT_W'(REF_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_wrap ? '0 : ref_cnt_q + CNT_W'(1);
      ref_pend_q <= (ref_pend_q && !ref_take) || ref_wrap;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    we      = 1'b0;
    load_rd = 1'b0;
`ifdef SDRAM_REFRESH_EN
    ref_take = 1'b0;
`endif
    case (state_q)
      INIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
`ifdef SDRAM_REFRESH_EN
        if (ref_pend_q) begin
          state_d  = REFRESH;
          cnt_d    = '0;
          ref_take = 1'b1;
        end else
`endif
        begin
          ready = 1'b1;
          if (bus.SDRAM_as) begin
            accept  = 1'b1;
            state_d = ACCESS;
            cnt_d   = '0;
          end
        end
      end
      ACCESS: begin
        we = (cnt_q == '0) && (rw_q == RW_WRITE);
        if (cnt_q == CNT_W'(ACC_LAT - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          load_rd = (rw_q == RW_READ);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
`ifdef SDRAM_REFRESH_EN
      REFRESH: begin
        if (cnt_q == CNT_W'(REF_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
    // Lost lock (or reset) abandons everything, including an uncommitted write.
    if (!bus.SDRAM_pll_locked || !rst_l) begin
      state_d = INIT;
      cnt_d   = '0;
      ready   = 1'b0;
      done    = 1'b0;
      accept  = 1'b0;
      we      = 1'b0;
      load_rd = 1'b0;
`ifdef SDRAM_REFRESH_EN
      ref_take = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= INIT;
      cnt_q   <= '0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rw_q    <= bus.SDRAM_rw;
        addr_q  <= bus.SDRAM_addr[DEPTH_LOG2-1:0];
        wdata_q <= bus.SDRAM_data_write;
      end
      if (load_rd) begin
        rdata_q <= store_rdata;
      end
    end
  end

  // Present the new address on accept so the read is ready well before DONE.
  assign store_addr = accept ? bus.SDRAM_addr[DEPTH_LOG2-1:0] : addr_q;

  sdram_word_store #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_store (
    .clk   (clk),
    .we    (we),
    .addr  (store_addr),
    .wdata (wdata_q),
    .rdata (store_rdata)
  );

  assign bus.SDRAM_ready     = ready;
  assign bus.SDRAM_done      = done;
  assign bus.SDRAM_data_read = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================
// tb_sdram_responder: directed + randomized checks against a word-array model
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
module tb_sdram_responder;
  import mem_pkg::*;

  localparam int DEPTH_LOG2  = 12;
  localparam int INIT_CYCLES = 16;
  localparam int ACC_LAT     = 3;
  localparam int REF_PERIOD  = 64;
  localparam int REF_CYCLES  = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  sdram_data_t model [int];

  sdram_responder_if bus();

  sdram_responder dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.SDRAM_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(bus.SDRAM_ready), 32'd1);
  endtask

  // One request through the protocol; latency and read data checked against the model.
  task automatic do_req(input logic rw, input sdram_addr_t a, input sdram_data_t d, input string tag);
    int lat;
    int idx = int'(a[DEPTH_LOG2-1:0]);
    wait_ready(tag);
    bus.SDRAM_as         = 1'b1;
    bus.SDRAM_rw         = rw;
    bus.SDRAM_addr       = a;
    bus.SDRAM_data_write = d;
    tick();
    bus.SDRAM_as         = 1'b0;
    bus.SDRAM_addr       = sdram_addr_t'($urandom);
    bus.SDRAM_data_write = sdram_data_t'($urandom);
    lat = 1;
    while (bus.SDRAM_done !== 1'b1 && lat < ACC_LAT + 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(ACC_LAT + 1));
    if (rw == RW_READ) begin
      if (model.exists(idx)) check({tag, "_rdata"}, 32'(bus.SDRAM_data_read), 32'(model[idx]));
    end else begin
      model[idx] = d;
    end
    tick();
    check({tag, "_done_pulse"}, 32'(bus.SDRAM_done), 32'd0);
`ifndef SDRAM_REFRESH_EN
    check({tag, "_ready_after"}, 32'(bus.SDRAM_ready), 32'd1);
`endif
    if (rw == RW_READ && model.exists(idx))
      check({tag, "_rdata_held"}, 32'(bus.SDRAM_data_read), 32'(model[idx]));
  endtask

  initial begin
    int n;
    int ndone;
    sdram_addr_t a;
    logic rw;

    bus.SDRAM_pll_locked = 1'b0;
    bus.SDRAM_as         = 1'b0;
    bus.SDRAM_rw         = RW_READ;
    bus.SDRAM_addr       = '0;
    bus.SDRAM_data_write = '0;
    rst_l = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(bus.SDRAM_ready), 32'd0);
    check("rst_done", 32'(bus.SDRAM_done), 32'd0);
    check("rst_data_read", 32'(bus.SDRAM_data_read), 32'd0);

    // Lock arrives with reset release; ready should follow after the init delay.
    rst_l = 1'b1;
    bus.SDRAM_pll_locked = 1'b1;
    n = 0;
    ndone = 0;
    while (bus.SDRAM_ready !== 1'b1 && n < 100) begin
      if (bus.SDRAM_done === 1'b1) ndone++;
      tick();
      n++;
    end
    check("init_delay", 32'(n), 32'(INIT_CYCLES));
    check("init_no_done", 32'(ndone), 32'd0);

    do_req(RW_WRITE, 23'h000005, 16'hBEEF, "wr_beef");
    do_req(RW_READ,  23'h000005, 16'h0000, "rd_beef");
    check("beef_value", 32'(bus.SDRAM_data_read), 32'h0000BEEF);

    do_req(RW_WRITE, 23'h001005, 16'h1234, "wr_alias");
    do_req(RW_READ,  23'h000005, 16'h0000, "rd_alias");
    check("alias_value", 32'(bus.SDRAM_data_read), 32'h00001234);

    // A strobe during ACCESS must vanish without side effects.
    do_req(RW_WRITE, 23'h000007, 16'h5A5A, "wr_seven");
    wait_ready("ign");
    bus.SDRAM_as   = 1'b1;
    bus.SDRAM_rw   = RW_READ;
    bus.SDRAM_addr = 23'h000007;
    tick();
    bus.SDRAM_rw         = RW_WRITE;
    bus.SDRAM_data_write = 16'hDEAD;
    tick();
    bus.SDRAM_as = 1'b0;
    ndone = 0;
    for (int i = 0; i < ACC_LAT + 8; i++) begin
      if (bus.SDRAM_done === 1'b1) ndone++;
      tick();
    end
    check("ign_one_done", 32'(ndone), 32'd1);
    do_req(RW_READ, 23'h000007, 16'h0000, "rd_seven");
    check("ign_prior_value", 32'(bus.SDRAM_data_read), 32'h00005A5A);

    // Lock lost in ACCESS: no done, full init delay after relock.
    wait_ready("pll");
    bus.SDRAM_as   = 1'b1;
    bus.SDRAM_rw   = RW_READ;
    bus.SDRAM_addr = 23'h000005;
    tick();
    bus.SDRAM_as = 1'b0;
    bus.SDRAM_pll_locked = 1'b0;
    tick();
    bus.SDRAM_pll_locked = 1'b1;
    n = 0;
    ndone = 0;
    while (bus.SDRAM_ready !== 1'b1 && n < 100) begin
      if (bus.SDRAM_done === 1'b1) ndone++;
      tick();
      n++;
    end
    check("pll_relock_delay", 32'(n), 32'(INIT_CYCLES));
    check("pll_no_done", 32'(ndone), 32'd0);

    // Random traffic over a small index window so reads hit written words.
    for (int i = 0; i < 40; i++) begin
      a = sdram_addr_t'($urandom);
      a[DEPTH_LOG2-1:0] = 12'($urandom_range(0, 15));
      rw = 1'($urandom);
      do_req(rw, a, sdram_data_t'($urandom), "rand");
    end

`ifdef SDRAM_REFRESH_EN
    wait_ready("ref");
    n = 0;
    while (bus.SDRAM_ready === 1'b1 && n < REF_PERIOD + 4) begin
      tick();
      n++;
    end
    check("ref_seen", 32'(n < REF_PERIOD + 4), 32'd1);
    bus.SDRAM_as         = 1'b1;
    bus.SDRAM_rw         = RW_WRITE;
    bus.SDRAM_addr       = 23'h000005;
    bus.SDRAM_data_write = 16'hDEAD;
    tick();
    bus.SDRAM_as = 1'b0;
    for (int i = 0; i < REF_CYCLES; i++) begin
      check("ref_busy_ready", 32'(bus.SDRAM_ready), 32'd0);
      check("ref_busy_done", 32'(bus.SDRAM_done), 32'd0);
      tick();
    end
    check("ref_ready_back", 32'(bus.SDRAM_ready), 32'd1);
    do_req(RW_READ,  23'h000005, 16'h0000, "ref_rd_prior");
    do_req(RW_WRITE, 23'h000005, 16'hDEAD, "ref_reissue_wr");
    do_req(RW_READ,  23'h000005, 16'h0000, "ref_reissue_rd");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
